data_bank_ctrl: RTL and testbench

- Sequencer and arbiter for the 4-entry, 32-bit data register bank that holds neuron-layer activations.
- Shares the bank between three requesters:
  - a host loader writing single words by address;
  - the neuron layer writing all four results at once;
  - a readout requester that streams the four stored words out in order.
- Drives the bank's write-address and write-all strobes and muxes its four outputs onto the stream port.

---
 rtl/data_bank_ctrl_pkg.sv | 24 ++
 rtl/data_bank_ctrl_rr_arbiter3.sv | 45 ++++
 rtl/data_bank_ctrl.sv | 157 +++++++++++++++
 tb/tb_data_bank_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bank_ctrl_pkg.sv
// Shared types and constants for the activation-bank sequencer.
// Requester indices double as bit positions in the arbiter request/grant vectors.
package data_bank_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_REGS_DEF   = 4;

    localparam int REQ_HOST   = 0;
    localparam int REQ_LAYER  = 1;
    localparam int REQ_STREAM = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOST_WR  = 2'd1,
        ST_LAYER_WR = 2'd2,
        ST_STREAM   = 2'd3
    } state_e;

    // Successor in the host -> layer -> stream ring.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/data_bank_ctrl_rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant, combinational from req and pointer.
// Pointer moves past the winner only on edges where upd_en_i is high.
module rr_arbiter3
    import data_bank_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_i,
    input  logic       upd_en_i,
    output logic [2:0] gnt_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;

    always_comb begin
        p0    = ptr_q;
        p1    = rr_next(p0);
        p2    = rr_next(p1);
        gnt_o = '0;
        ptr_d = ptr_q;
        if (req_i[p0]) begin
            gnt_o[p0] = 1'b1;
            ptr_d     = p1;
        end else if (req_i[p1]) begin
            gnt_o[p1] = 1'b1;
            ptr_d     = p2;
        end else if (req_i[p2]) begin
            gnt_o[p2] = 1'b1;
            ptr_d     = p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'(REQ_HOST);
        end else if (upd_en_i && (|gnt_o)) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/data_bank_ctrl.sv
// Arbitrates host single-word writes, layer four-word writes and readout streaming
// over a 4x32 register bank; strobes are registered one-cycle pulses.
module data_bank_ctrl
    import data_bank_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [1:0]            host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  layer_valid,
    output logic                  layer_ready,
    input  logic [DATA_WIDTH-1:0] layer_data0,
    input  logic [DATA_WIDTH-1:0] layer_data1,
    input  logic [DATA_WIDTH-1:0] layer_data2,
    input  logic [DATA_WIDTH-1:0] layer_data3,
    input  logic                  stream_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  stream_done,
    output logic [DATA_WIDTH-1:0] bank_data_in,
    output logic [1:0]            bank_address,
    output logic                  bank_write_address,
    output logic                  bank_write_all,
    output logic [DATA_WIDTH-1:0] bank_in0,
    output logic [DATA_WIDTH-1:0] bank_in1,
    output logic [DATA_WIDTH-1:0] bank_in2,
    output logic [DATA_WIDTH-1:0] bank_in3,
    input  logic [DATA_WIDTH-1:0] bank_out0,
    input  logic [DATA_WIDTH-1:0] bank_out1,
    input  logic [DATA_WIDTH-1:0] bank_out2,
    input  logic [DATA_WIDTH-1:0] bank_out3,
    output logic                  busy
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_REGS - 1);

    state_e                state_q;
    logic [1:0]            idx_q;
    logic                  stream_done_q;
    logic                  wr_addr_q;
    logic                  wr_all_q;
    logic [1:0]            addr_q;
    logic [DATA_WIDTH-1:0] data_in_q;
    logic [DATA_WIDTH-1:0] in0_q;
    logic [DATA_WIDTH-1:0] in1_q;
    logic [DATA_WIDTH-1:0] in2_q;
    logic [DATA_WIDTH-1:0] in3_q;

    logic [2:0]            req;
    logic [2:0]            gnt;
    logic                  idle;
    logic [DATA_WIDTH-1:0] stream_word;

    assign idle            = (state_q == ST_IDLE);
    assign req[REQ_HOST]   = host_valid;
    assign req[REQ_LAYER]  = layer_valid;
    assign req[REQ_STREAM] = stream_req;

    rr_arbiter3 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .upd_en_i (idle),
        .gnt_o    (gnt)
    );

    // Readies are gated by rst_n so they drop the instant reset asserts.
    assign host_ready  = rst_n && idle && gnt[REQ_HOST];
    assign layer_ready = rst_n && idle && gnt[REQ_LAYER];

    always_comb begin
        stream_word = bank_out0;
        case (idx_q)
            2'd1:    stream_word = bank_out1;
            2'd2:    stream_word = bank_out2;
            2'd3:    stream_word = bank_out3;
            default: stream_word = bank_out0;
        endcase
    end

    assign out_valid          = (state_q == ST_STREAM);
    assign out_data           = out_valid ? stream_word : '0;
    assign out_last           = out_valid && (idx_q == LAST_IDX);
    assign stream_done        = stream_done_q;
    assign busy               = !idle;
    assign bank_write_address = wr_addr_q;
    assign bank_write_all     = wr_all_q;
    assign bank_address       = addr_q;
    assign bank_data_in       = data_in_q;
    assign bank_in0           = in0_q;
    assign bank_in1           = in1_q;
    assign bank_in2           = in2_q;
    assign bank_in3           = in3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            stream_done_q <= 1'b0;
            wr_addr_q     <= 1'b0;
            wr_all_q      <= 1'b0;
            addr_q        <= '0;
            data_in_q     <= '0;
            in0_q         <= '0;
            in1_q         <= '0;
            in2_q         <= '0;
            in3_q         <= '0;
        end else begin
            stream_done_q <= 1'b0;
            wr_addr_q     <= 1'b0;
            wr_all_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt[REQ_HOST]) begin
                        addr_q    <= host_addr;
                        data_in_q <= host_data;
                        wr_addr_q <= 1'b1;
                        state_q   <= ST_HOST_WR;
                    end else if (gnt[REQ_LAYER]) begin
                        in0_q    <= layer_data0;
                        in1_q    <= layer_data1;
                        in2_q    <= layer_data2;
                        in3_q    <= layer_data3;
                        wr_all_q <= 1'b1;
                        state_q  <= ST_LAYER_WR;
                    end else if (gnt[REQ_STREAM]) begin
                        idx_q   <= '0;
                        state_q <= ST_STREAM;
                    end
                end
                ST_HOST_WR, ST_LAYER_WR: begin
                    state_q <= ST_IDLE;
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q         <= '0;
                            stream_done_q <= 1'b1;
                            state_q       <= ST_IDLE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bank_ctrl.sv
// Directed bench for data_bank_ctrl with a behavioural 4x32 register bank.
module tb_data_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_valid, host_ready;
    logic [1:0]  host_addr;
    logic [31:0] host_data;
    logic        layer_valid, layer_ready;
    logic [31:0] layer_data0, layer_data1, layer_data2, layer_data3;
    logic        stream_req, out_valid, out_ready, out_last, stream_done;
    logic [31:0] out_data;
    logic [31:0] bank_data_in;
    logic [1:0]  bank_address;
    logic        bank_write_address, bank_write_all, busy;
    logic [31:0] bank_in0, bank_in1, bank_in2, bank_in3;
    logic [31:0] bank_r [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Bank registers capture on the edge that closes a strobe cycle.
    always @(posedge clk) begin
        if (bank_write_address) bank_r[bank_address] <= bank_data_in;
        if (bank_write_all) begin
            bank_r[0] <= bank_in0;
            bank_r[1] <= bank_in1;
            bank_r[2] <= bank_in2;
            bank_r[3] <= bank_in3;
        end
    end

    data_bank_ctrl #(.DATA_WIDTH(32), .NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .layer_valid(layer_valid), .layer_ready(layer_ready),
        .layer_data0(layer_data0), .layer_data1(layer_data1),
        .layer_data2(layer_data2), .layer_data3(layer_data3),
        .stream_req(stream_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .stream_done(stream_done),
        .bank_data_in(bank_data_in), .bank_address(bank_address),
        .bank_write_address(bank_write_address), .bank_write_all(bank_write_all),
        .bank_in0(bank_in0), .bank_in1(bank_in1), .bank_in2(bank_in2), .bank_in3(bank_in3),
        .bank_out0(bank_r[0]), .bank_out1(bank_r[1]), .bank_out2(bank_r[2]), .bank_out3(bank_r[3]),
        .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        host_valid = 0; host_addr = 0; host_data = 0;
        layer_valid = 0; layer_data0 = 0; layer_data1 = 0; layer_data2 = 0; layer_data3 = 0;
        stream_req = 0; out_ready = 0;
        for (int i = 0; i < 4; i++) bank_r[i] = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({host_ready, layer_ready, out_valid, out_last, stream_done, bank_write_address,
             bank_write_all, busy, bank_address} !== 10'b0 ||
            (out_data | bank_data_in | bank_in0 | bank_in1 | bank_in2 | bank_in3) !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b busy=%b out_data=%h din=%h need all zero",
                     {host_ready, layer_ready, out_valid, out_last, stream_done,
                      bank_write_address, bank_write_all}, busy, out_data, bank_data_in);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_host_writes;
        int n;
        for (int a = 0; a < 4; a++) begin
            host_valid = 1; host_addr = 2'(a); host_data = 32'hA0 + 32'(a);
            n = 0;
            @(negedge clk);
            while (!host_ready && n < 8) begin @(negedge clk); n++; end
            checks++;
            if (host_ready !== 1'b1) begin
                errors++;
                $display("FAIL host_accept_%0d: host_ready=%b need 1", a, host_ready);
            end
            tick();
            host_valid = 0;
            @(negedge clk);
            checks++;
            if (bank_write_address !== 1'b1 || bank_write_all !== 1'b0 || host_ready !== 1'b0 ||
                bank_address !== 2'(a)) begin
                errors++;
                $display("FAIL host_strobe_%0d: wa=%b wall=%b rdy=%b addr=%0d need 1,0,0,%0d",
                         a, bank_write_address, bank_write_all, host_ready, bank_address, a);
            end
            tick();
            @(negedge clk);
            checks++;
            if (bank_write_address !== 1'b0 || bank_r[a] !== 32'hA0 + 32'(a) || busy !== 1'b0) begin
                errors++;
                $display("FAIL host_data_%0d: wa=%b bank=%h busy=%b need 0,%h,0",
                         a, bank_write_address, bank_r[a], busy, 32'hA0 + 32'(a));
            end
            tick();
        end
    endtask

    task automatic test_layer_write;
        int n;
        layer_valid = 1;
        layer_data0 = 10; layer_data1 = 11; layer_data2 = 12; layer_data3 = 13;
        n = 0;
        @(negedge clk);
        while (!layer_ready && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (layer_ready !== 1'b1) begin
            errors++;
            $display("FAIL layer_accept: layer_ready=%b need 1", layer_ready);
        end
        tick();
        layer_valid = 0;
        @(negedge clk);
        checks++;
        if (bank_write_all !== 1'b1 || bank_write_address !== 1'b0 || layer_ready !== 1'b0) begin
            errors++;
            $display("FAIL layer_strobe: wall=%b wa=%b rdy=%b need 1,0,0",
                     bank_write_all, bank_write_address, layer_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bank_r[0] !== 32'd10 || bank_r[1] !== 32'd11 || bank_r[2] !== 32'd12 ||
            bank_r[3] !== 32'd13 || bank_write_all !== 1'b0 || bank_write_address !== 1'b0) begin
            errors++;
            $display("FAIL layer_data: bank=%0d,%0d,%0d,%0d wall=%b wa=%b need 10,11,12,13,0,0",
                     bank_r[0], bank_r[1], bank_r[2], bank_r[3], bank_write_all, bank_write_address);
        end
        tick();
    endtask

    task automatic test_arbitration;
        int n;
        logic [1:0] exp_rdy;
        host_valid = 1; host_addr = 0; host_data = 32'hB0;
        layer_valid = 1;
        layer_data0 = 10; layer_data1 = 11; layer_data2 = 12; layer_data3 = 13;
        for (int g = 0; g < 4; g++) begin
            exp_rdy = (g % 2 == 0) ? 2'b10 : 2'b01;
            n = 0;
            @(negedge clk);
            while (!(host_ready || layer_ready) && n < 8) begin @(negedge clk); n++; end
            checks++;
            if ({host_ready, layer_ready} !== exp_rdy) begin
                errors++;
                $display("FAIL arb_grant_%0d: {host,layer}_ready=%b need %b",
                         g, {host_ready, layer_ready}, exp_rdy);
            end
            tick();
            if (g == 3) begin host_valid = 0; layer_valid = 0; end
            @(negedge clk);
            checks++;
            if ({bank_write_address, bank_write_all} !== exp_rdy) begin
                errors++;
                $display("FAIL arb_strobe_%0d: {wa,wall}=%b need %b",
                         g, {bank_write_address, bank_write_all}, exp_rdy);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_stream;
        logic [5:0] pat;
        int w;
        pat = 6'b101101;
        w = 0;
        stream_req = 1; out_ready = 0;
        tick();
        stream_req = 0;
        host_valid = 1; host_addr = 2; host_data = 32'h77;
        for (int k = 0; k < 6; k++) begin
            out_ready = pat[k];
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd10 + 32'(w) || out_last !== (w == 3) ||
                host_ready !== 1'b0 || stream_done !== 1'b0 || bank_write_address !== 1'b0) begin
                errors++;
                $display("FAIL stream_word_%0d: vld=%b data=%0d last=%b hrdy=%b done=%b need 1,%0d,%b,0,0",
                         k, out_valid, out_data, out_last, host_ready, stream_done, 10 + w, w == 3);
            end
            if (pat[k]) w++;
            tick();
        end
        out_ready = 0;
        @(negedge clk);
        checks++;
        if (stream_done !== 1'b1 || out_valid !== 1'b0 || host_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_done: done=%b vld=%b hrdy=%b need 1,0,1", stream_done, out_valid, host_ready);
        end
        tick();
        host_valid = 0;
        @(negedge clk);
        checks++;
        if (stream_done !== 1'b0 || bank_write_address !== 1'b1 || bank_address !== 2'd2) begin
            errors++;
            $display("FAIL stream_pending_host: done=%b wa=%b addr=%0d need 0,1,2",
                     stream_done, bank_write_address, bank_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bank_r[2] !== 32'h77 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_host_data: bank2=%h busy=%b need 77,0", bank_r[2], busy);
        end
        tick();
    endtask

    task automatic test_reset_mid_stream;
        int n;
        logic seen_done;
        stream_req = 1; out_ready = 1;
        tick();
        stream_req = 0;
        tick();
        tick();
        out_ready = 0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h77) begin
            errors++;
            $display("FAIL rst_stream_idx2: vld=%b data=%h need 1,77", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 || stream_done !== 1'b0 ||
            out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_immediate: vld=%b busy=%b data=%h done=%b last=%b need all 0",
                     out_valid, busy, out_data, stream_done, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (3) begin @(negedge clk); seen_done |= stream_done; end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: stream_done seen=%b need 0", seen_done);
        end
        tick();
        host_valid = 1; host_addr = 1; host_data = 32'h55;
        n = 0;
        @(negedge clk);
        while (!host_ready && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (host_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_host_accept: host_ready=%b need 1", host_ready);
        end
        tick();
        host_valid = 0;
        tick();
        @(negedge clk);
        checks++;
        if (bank_r[1] !== 32'h55) begin
            errors++;
            $display("FAIL rst_host_data: bank1=%h need 55", bank_r[1]);
        end
        tick();
    endtask

    task automatic test_all_three;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        host_valid = 1; host_addr = 0; host_data = 32'hC0;
        layer_valid = 1;
        layer_data0 = 20; layer_data1 = 21; layer_data2 = 22; layer_data3 = 23;
        stream_req = 1; out_ready = 1;
        @(negedge clk);
        checks++;
        if (host_ready !== 1'b1 || layer_ready !== 1'b0) begin
            errors++;
            $display("FAIL all3_first_host: hrdy=%b lrdy=%b need 1,0", host_ready, layer_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bank_write_address !== 1'b1 || bank_write_all !== 1'b0) begin
            errors++;
            $display("FAIL all3_host_strobe: wa=%b wall=%b need 1,0", bank_write_address, bank_write_all);
        end
        tick();
        @(negedge clk);
        checks++;
        if (host_ready !== 1'b0 || layer_ready !== 1'b1) begin
            errors++;
            $display("FAIL all3_second_layer: hrdy=%b lrdy=%b need 0,1", host_ready, layer_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bank_write_all !== 1'b1 || bank_write_address !== 1'b0) begin
            errors++;
            $display("FAIL all3_layer_strobe: wall=%b wa=%b need 1,0", bank_write_all, bank_write_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if (host_ready !== 1'b0 || layer_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL all3_third_stream: hrdy=%b lrdy=%b busy=%b vld=%b need 0,0,0,0",
                     host_ready, layer_ready, busy, out_valid);
        end
        tick();
        stream_req = 0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd20 + 32'(w) || out_last !== (w == 3)) begin
                errors++;
                $display("FAIL all3_stream_%0d: vld=%b data=%0d last=%b need 1,%0d,%b",
                         w, out_valid, out_data, out_last, 20 + w, w == 3);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (stream_done !== 1'b1 || host_ready !== 1'b1 || layer_ready !== 1'b0) begin
            errors++;
            $display("FAIL all3_ptr_back_host: done=%b hrdy=%b lrdy=%b need 1,1,0",
                     stream_done, host_ready, layer_ready);
        end
        tick();
        host_valid = 0; layer_valid = 0; out_ready = 0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_host_writes();
        test_layer_write();
        test_arbitration();
        test_stream();
        test_reset_mid_stream();
        test_all_three();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
